// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter with registered bus outputs and an ack timeout.
// Define ZAP_WB_RR_EN to alternate grants between simultaneous requesters instead of fixed m0 priority.
module zap_wb_arbiter #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_cyc_nxt,
    input  logic        i_m0_stb_nxt,
    input  logic        i_m0_wen_nxt,
    input  logic [31:0] i_m0_adr_nxt,
    input  logic [3:0]  i_m0_sel_nxt,
    input  logic [31:0] i_m0_dat_nxt,

    input  logic        i_m1_cyc_nxt,
    input  logic        i_m1_stb_nxt,
    input  logic        i_m1_wen_nxt,
    input  logic [31:0] i_m1_adr_nxt,
    input  logic [3:0]  i_m1_sel_nxt,
    input  logic [31:0] i_m1_dat_nxt,

    output logic        o_m0_ack,
    output logic        o_m1_ack,
    output logic        o_m0_err,
    output logic        o_m1_err,
    output logic [31:0] o_m_dat,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    wb_req_t     bus_q, bus_d;
    wb_req_t     m0_req, m1_req;
    logic [15:0] tmo_q, tmo_d, tmo_run;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic        grant0, grant1;
    logic        timeout;

    assign m0_req = '{i_m0_cyc_nxt, i_m0_stb_nxt, i_m0_wen_nxt,
                      i_m0_adr_nxt, i_m0_sel_nxt, i_m0_dat_nxt};
    assign m1_req = '{i_m1_cyc_nxt, i_m1_stb_nxt, i_m1_wen_nxt,
                      i_m1_adr_nxt, i_m1_sel_nxt, i_m1_dat_nxt};

    // Ending a transfer clears only the controls; address/sel/data keep their last values.
    function automatic wb_req_t drop_bus(input wb_req_t b);
        wb_req_t r;
        r     = b;
        r.cyc = 1'b0;
        r.stb = 1'b0;
        r.we  = 1'b0;
        return r;
    endfunction

`ifdef ZAP_WB_RR_EN
    logic last_m1_q, last_m1_d;   // 1 when master 1 received the most recent grant

    assign grant0 = i_m0_cyc_nxt && (!i_m1_cyc_nxt || last_m1_q);

    always_comb begin
        last_m1_d = last_m1_q;
        if (state_q == IDLE) begin
            if (grant0)
                last_m1_d = 1'b0;
            else if (grant1)
                last_m1_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            last_m1_q <= 1'b1;
        else
            last_m1_q <= last_m1_d;
    end
`else
    assign grant0 = i_m0_cyc_nxt;
`endif

    assign grant1 = i_m1_cyc_nxt && !grant0;

    // An ack in the last allowed cycle beats the timeout.
    assign timeout = bus_q.stb && !i_wb_ack && (tmo_q == TMO_LAST);
    assign tmo_run = i_wb_ack ? 16'd0 : (bus_q.stb ? tmo_q + 16'd1 : tmo_q);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        tmo_d   = tmo_q;
        err0_d  = 1'b0;
        err1_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = 16'd0;
                if (grant0) begin
                    state_d = OWN0;
                    bus_d   = m0_req;
                end else if (grant1) begin
                    state_d = OWN1;
                    bus_d   = m1_req;
                end
            end

            OWN0: begin
                if (timeout) begin
                    state_d = IDLE;
                    bus_d   = drop_bus(bus_q);
                    tmo_d   = 16'd0;
                    err0_d  = 1'b1;
                end else if (!i_m0_cyc_nxt) begin
                    state_d = IDLE;
                    bus_d   = drop_bus(bus_q);
                    tmo_d   = 16'd0;
                end else begin
                    bus_d = m0_req;
                    tmo_d = tmo_run;
                end
            end

            OWN1: begin
                if (timeout) begin
                    state_d = IDLE;
                    bus_d   = drop_bus(bus_q);
                    tmo_d   = 16'd0;
                    err1_d  = 1'b1;
                end else if (!i_m1_cyc_nxt) begin
                    state_d = IDLE;
                    bus_d   = drop_bus(bus_q);
                    tmo_d   = 16'd0;
                end else begin
                    bus_d = m1_req;
                    tmo_d = tmo_run;
                end
            end

            default: begin
                state_d = IDLE;
                bus_d   = drop_bus(bus_q);
                tmo_d   = 16'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            bus_q   <= '0;
            tmo_q   <= 16'd0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            tmo_q   <= tmo_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    // Acks are masked during reset so an abandoned transfer never completes.
    assign o_m0_ack = i_wb_ack && (state_q == OWN0) && !i_reset;
    assign o_m1_ack = i_wb_ack && (state_q == OWN1) && !i_reset;
    assign o_m0_err = err0_q;
    assign o_m1_err = err1_q;
    assign o_m_dat  = i_wb_dat;

    assign o_wb_cyc = bus_q.cyc;
    assign o_wb_stb = bus_q.stb;
    assign o_wb_we  = bus_q.we;
    assign o_wb_adr = bus_q.adr;
    assign o_wb_sel = bus_q.sel;
    assign o_wb_dat = bus_q.dat;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter (ACK_TIMEOUT=4): reset, single read, burst handover,
// simultaneous requests, timeout, ack on the timeout cycle and reset mid-transfer.
module tb_zap_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_m0_cyc_nxt, i_m0_stb_nxt, i_m0_wen_nxt;
    logic [31:0] i_m0_adr_nxt, i_m0_dat_nxt;
    logic [3:0]  i_m0_sel_nxt;
    logic        i_m1_cyc_nxt, i_m1_stb_nxt, i_m1_wen_nxt;
    logic [31:0] i_m1_adr_nxt, i_m1_dat_nxt;
    logic [3:0]  i_m1_sel_nxt;
    logic        o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
    logic [31:0] o_m_dat;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    zap_wb_arbiter #(.ACK_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_cyc_nxt(i_m0_cyc_nxt), .i_m0_stb_nxt(i_m0_stb_nxt), .i_m0_wen_nxt(i_m0_wen_nxt),
        .i_m0_adr_nxt(i_m0_adr_nxt), .i_m0_sel_nxt(i_m0_sel_nxt), .i_m0_dat_nxt(i_m0_dat_nxt),
        .i_m1_cyc_nxt(i_m1_cyc_nxt), .i_m1_stb_nxt(i_m1_stb_nxt), .i_m1_wen_nxt(i_m1_wen_nxt),
        .i_m1_adr_nxt(i_m1_adr_nxt), .i_m1_sel_nxt(i_m1_sel_nxt), .i_m1_dat_nxt(i_m1_dat_nxt),
        .o_m0_ack(o_m0_ack), .o_m1_ack(o_m1_ack), .o_m0_err(o_m0_err), .o_m1_err(o_m1_err),
        .o_m_dat(o_m_dat),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic wen,
                            input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        i_m0_cyc_nxt = cyc; i_m0_stb_nxt = stb; i_m0_wen_nxt = wen;
        i_m0_adr_nxt = adr; i_m0_sel_nxt = sel; i_m0_dat_nxt = dat;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic wen,
                            input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        i_m1_cyc_nxt = cyc; i_m1_stb_nxt = stb; i_m1_wen_nxt = wen;
        i_m1_adr_nxt = adr; i_m1_sel_nxt = sel; i_m1_dat_nxt = dat;
    endtask

    task automatic test_reset();
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        drive_m1(0, 0, 0, 32'h0, 4'h0, 32'h0);
        i_wb_dat = 32'h0;
        i_wb_ack = 1'b1;
        i_reset  = 1'b1;
        step(); step();
        sample();
        chk_cnt++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) $display("FAIL rst_ctrl got=%0b exp=000", {o_wb_cyc, o_wb_stb, o_wb_we}); else pass_cnt++;
        chk_cnt++; if (o_wb_adr !== 32'h0) $display("FAIL rst_adr got=%0h exp=0", o_wb_adr); else pass_cnt++;
        chk_cnt++; if (o_wb_sel !== 4'h0) $display("FAIL rst_sel got=%0h exp=0", o_wb_sel); else pass_cnt++;
        chk_cnt++; if (o_wb_dat !== 32'h0) $display("FAIL rst_dat got=%0h exp=0", o_wb_dat); else pass_cnt++;
        chk_cnt++; if ({o_m0_err, o_m1_err} !== 2'b00) $display("FAIL rst_err got=%0b exp=00", {o_m0_err, o_m1_err}); else pass_cnt++;
        chk_cnt++; if ({o_m0_ack, o_m1_ack} !== 2'b00) $display("FAIL rst_ack got=%0b exp=00", {o_m0_ack, o_m1_ack}); else pass_cnt++;
        step();
        i_reset  = 1'b0;
        i_wb_ack = 1'b0;
    endtask

    task automatic test_m0_read();
        drive_m0(1, 1, 0, 32'h0000_4000, 4'hF, 32'h0);
        sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL rd_req_cycle_cyc got=%0b exp=0", o_wb_cyc); else pass_cnt++;
        step(); sample();
        chk_cnt++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b110) $display("FAIL rd_ctrl got=%0b exp=110", {o_wb_cyc, o_wb_stb, o_wb_we}); else pass_cnt++;
        chk_cnt++; if (o_wb_adr !== 32'h0000_4000) $display("FAIL rd_adr got=%0h exp=4000", o_wb_adr); else pass_cnt++;
        chk_cnt++; if (o_wb_sel !== 4'hF) $display("FAIL rd_sel got=%0h exp=f", o_wb_sel); else pass_cnt++;
        step(); step(); sample();
        chk_cnt++; if ({o_wb_cyc, o_m0_ack} !== 2'b10) $display("FAIL rd_wait got=%0b exp=10", {o_wb_cyc, o_m0_ack}); else pass_cnt++;
        step();
        i_wb_ack = 1'b1;
        i_wb_dat = 32'hDEAD_BEEF;
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if ({o_m0_ack, o_m1_ack} !== 2'b10) $display("FAIL rd_ack got=%0b exp=10", {o_m0_ack, o_m1_ack}); else pass_cnt++;
        chk_cnt++; if (o_m_dat !== 32'hDEAD_BEEF) $display("FAIL rd_dat got=%0h exp=deadbeef", o_m_dat); else pass_cnt++;
        chk_cnt++; if (o_m0_err !== 1'b0) $display("FAIL rd_err got=%0b exp=0", o_m0_err); else pass_cnt++;
        step(); sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL rd_end_cyc got=%0b exp=0", o_wb_cyc); else pass_cnt++;
        chk_cnt++; if (o_wb_adr !== 32'h0000_4000) $display("FAIL rd_adr_hold got=%0h exp=4000", o_wb_adr); else pass_cnt++;
        chk_cnt++; if ({o_m0_ack, o_m0_err} !== 2'b00) $display("FAIL rd_idle_ack_err got=%0b exp=00", {o_m0_ack, o_m0_err}); else pass_cnt++;
        i_wb_ack = 1'b0;
    endtask

    task automatic test_burst_handover();
        logic [31:0] exp_adr;
        int          m1_acks;
        m1_acks = 0;
        drive_m1(1, 1, 1, 32'h100, 4'hF, 32'h11);
        for (int k = 0; k < 4; k++) begin
            step();
            i_wb_ack = 1'b1;
            if (k == 0) drive_m0(1, 1, 0, 32'h8000, 4'h3, 32'h0);
            if (k < 3) drive_m1(1, 1, 1, 32'h100 + 32'(4 * (k + 1)), 4'hF, 32'h11 + 32'(k + 1));
            else       drive_m1(0, 0, 0, 32'h0, 4'h0, 32'h0);
            exp_adr = 32'h100 + 32'(4 * k);
            sample();
            if (o_m1_ack === 1'b1) m1_acks++;
            chk_cnt++; if (o_wb_adr !== exp_adr) $display("FAIL burst_adr beat=%0d got=%0h exp=%0h", k, o_wb_adr, exp_adr); else pass_cnt++;
            chk_cnt++; if (o_wb_dat !== 32'h11 + 32'(k)) $display("FAIL burst_dat beat=%0d got=%0h exp=%0h", k, o_wb_dat, 32'h11 + 32'(k)); else pass_cnt++;
            chk_cnt++; if ({o_wb_cyc, o_wb_we, o_m0_ack} !== 3'b110) $display("FAIL burst_ctrl beat=%0d got=%0b exp=110", k, {o_wb_cyc, o_wb_we, o_m0_ack}); else pass_cnt++;
        end
        chk_cnt++; if (m1_acks != 4) $display("FAIL burst_m1_acks got=%0d exp=4", m1_acks); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL burst_gap_cyc got=%0b exp=0", o_wb_cyc); else pass_cnt++;
        step();
        i_wb_ack = 1'b1;
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if ({o_wb_cyc, o_wb_we} !== 2'b10) $display("FAIL m0_after_burst_ctrl got=%0b exp=10", {o_wb_cyc, o_wb_we}); else pass_cnt++;
        chk_cnt++; if (o_wb_adr !== 32'h8000) $display("FAIL m0_after_burst_adr got=%0h exp=8000", o_wb_adr); else pass_cnt++;
        chk_cnt++; if ({o_m0_ack, o_m1_ack} !== 2'b10) $display("FAIL m0_after_burst_ack got=%0b exp=10", {o_m0_ack, o_m1_ack}); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL m0_after_burst_end got=%0b exp=0", o_wb_cyc); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic        rr;
        logic [31:0] exp_adr2;
`ifdef ZAP_WB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        exp_adr2 = rr ? 32'hB0 : 32'hA4;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        drive_m0(1, 1, 0, 32'hA0, 4'hF, 32'h0);
        drive_m1(1, 1, 0, 32'hB0, 4'hF, 32'h0);
        step();
        i_wb_ack = 1'b1;
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if (o_wb_adr !== 32'hA0) $display("FAIL sim1_adr got=%0h exp=a0", o_wb_adr); else pass_cnt++;
        chk_cnt++; if ({o_m0_ack, o_m1_ack} !== 2'b10) $display("FAIL sim1_owner got=%0b exp=10", {o_m0_ack, o_m1_ack}); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        drive_m0(1, 1, 0, 32'hA4, 4'hF, 32'h0);
        sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL sim_gap_cyc got=%0b exp=0", o_wb_cyc); else pass_cnt++;
        step();
        i_wb_ack = 1'b1;
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        drive_m1(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if (o_wb_adr !== exp_adr2) $display("FAIL sim2_adr got=%0h exp=%0h", o_wb_adr, exp_adr2); else pass_cnt++;
        chk_cnt++; if ({o_m0_ack, o_m1_ack} !== {~rr, rr}) $display("FAIL sim2_owner got=%0b exp=%0b", {o_m0_ack, o_m1_ack}, {~rr, rr}); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL sim_end_cyc got=%0b exp=0", o_wb_cyc); else pass_cnt++;
    endtask

    task automatic test_timeout();
        drive_m1(1, 1, 1, 32'hC0, 4'hF, 32'h55);
        for (int k = 0; k < 4; k++) begin
            step(); sample();
            chk_cnt++; if ({o_wb_cyc, o_wb_stb, o_m1_err, o_m1_ack} !== 4'b1100) $display("FAIL tmo_wait cyc=%0d got=%0b exp=1100", k, {o_wb_cyc, o_wb_stb, o_m1_err, o_m1_ack}); else pass_cnt++;
        end
        step();
        drive_m1(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) $display("FAIL tmo_drop got=%0b exp=000", {o_wb_cyc, o_wb_stb, o_wb_we}); else pass_cnt++;
        chk_cnt++; if ({o_m1_err, o_m0_err, o_m1_ack} !== 3'b100) $display("FAIL tmo_err got=%0b exp=100", {o_m1_err, o_m0_err, o_m1_ack}); else pass_cnt++;
        step(); sample();
        chk_cnt++; if ({o_m1_err, o_wb_cyc} !== 2'b00) $display("FAIL tmo_err_pulse got=%0b exp=00", {o_m1_err, o_wb_cyc}); else pass_cnt++;
        chk_cnt++; if (o_wb_adr !== 32'hC0) $display("FAIL tmo_adr_hold got=%0h exp=c0", o_wb_adr); else pass_cnt++;
    endtask

    task automatic test_ack_at_timeout();
        drive_m0(1, 1, 1, 32'hE0, 4'hF, 32'h77);
        step(); step(); step(); sample();
        chk_cnt++; if ({o_wb_cyc, o_m0_err} !== 2'b10) $display("FAIL ackt_wait got=%0b exp=10", {o_wb_cyc, o_m0_err}); else pass_cnt++;
        step();
        i_wb_ack = 1'b1;
        drive_m0(1, 1, 1, 32'hE4, 4'hF, 32'h78);
        sample();
        chk_cnt++; if ({o_m0_ack, o_m0_err} !== 2'b10) $display("FAIL ackt_ack got=%0b exp=10", {o_m0_ack, o_m0_err}); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        sample();
        chk_cnt++; if ({o_wb_cyc, o_m0_err} !== 2'b10) $display("FAIL ackt_no_term got=%0b exp=10", {o_wb_cyc, o_m0_err}); else pass_cnt++;
        chk_cnt++; if (o_wb_adr !== 32'hE4) $display("FAIL ackt_beat2_adr got=%0h exp=e4", o_wb_adr); else pass_cnt++;
        step();
        i_wb_ack = 1'b1;
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if (o_m0_ack !== 1'b1) $display("FAIL ackt_beat2_ack got=%0b exp=1", o_m0_ack); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        sample();
        chk_cnt++; if ({o_wb_cyc, o_m0_err} !== 2'b00) $display("FAIL ackt_end got=%0b exp=00", {o_wb_cyc, o_m0_err}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive_m0(1, 1, 0, 32'hF0, 4'hF, 32'h0);
        step(); sample();
        chk_cnt++; if (o_wb_cyc !== 1'b1) $display("FAIL rmid_own got=%0b exp=1", o_wb_cyc); else pass_cnt++;
        step();
        i_reset  = 1'b1;
        i_wb_ack = 1'b1;
        sample();
        chk_cnt++; if ({o_m0_ack, o_m0_err, o_m1_ack} !== 3'b000) $display("FAIL rmid_during got=%0b exp=000", {o_m0_ack, o_m0_err, o_m1_ack}); else pass_cnt++;
        step();
        i_reset = 1'b0;
        drive_m0(0, 0, 0, 32'h0, 4'h0, 32'h0);
        sample();
        chk_cnt++; if ({o_wb_cyc, o_wb_stb} !== 2'b00) $display("FAIL rmid_drop got=%0b exp=00", {o_wb_cyc, o_wb_stb}); else pass_cnt++;
        chk_cnt++; if ({o_m0_ack, o_m0_err} !== 2'b00) $display("FAIL rmid_idle got=%0b exp=00", {o_m0_ack, o_m0_err}); else pass_cnt++;
        step();
        i_wb_ack = 1'b0;
        sample();
        chk_cnt++; if (o_wb_cyc !== 1'b0) $display("FAIL rmid_after got=%0b exp=0", o_wb_cyc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_burst_handover();
        test_simultaneous();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
